// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: table-driven phase-increment sequencer feeding wave_gen_CORDIC i_phi.
// Optional macro WSEQ_SETTLE_EN inserts a SETTLE_CYC blanking state after every phase hop.
module wave_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter int PHI_W = 16,
  parameter int DWELL_W = 24
`ifdef WSEQ_SETTLE_EN
  , parameter int SETTLE_CYC = 20
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [PHI_W-1:0]   i_wr_phi,
  input  logic [DWELL_W-1:0] i_wr_dwell,
  input  logic [ADDR_W:0]    i_len,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_loop,
  output logic [PHI_W-1:0]   o_phi,
  output logic               o_valid,
  output logic               o_step,
  output logic [ADDR_W-1:0]  o_idx,
  output logic               o_busy,
  output logic               o_done
);
`ifdef WSEQ_SETTLE_EN
  typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;
`else
  typedef enum logic [1:0] {IDLE, DWELL} state_t;
`endif
  localparam logic [ADDR_W:0] LEN_MAX = DEPTH[ADDR_W:0];
  state_t state, nxt;
  logic [PHI_W-1:0]   phi_tab [DEPTH];
  logic [DWELL_W-1:0] dw_tab [DEPTH];
  logic [DWELL_W-1:0] cnt, n_cnt, dw;
  logic [ADDR_W:0]    len, n_len;
  logic [PHI_W-1:0]   n_phi;
  logic [ADDR_W-1:0]  n_idx, eidx;
  logic               n_valid, n_step, n_busy, n_done, enter;
  always_comb begin
    nxt = state;
    n_cnt = cnt;
    n_len = len;
    n_phi = o_phi;
    n_idx = o_idx;
    n_valid = o_valid;
    n_step = 1'b0;
    n_busy = o_busy;
    n_done = 1'b0;
    enter = 1'b0;
    eidx = '0;
    if (state == IDLE) begin
      if (i_start && i_len != '0) begin
        n_len = (i_len > LEN_MAX) ? LEN_MAX : i_len;
        enter = 1'b1;
      end
    end else if (i_stop) begin
      nxt = IDLE;
      n_valid = 1'b0;
      n_busy = 1'b0;
    end else if (cnt != DWELL_W'(1)) begin
      n_cnt = cnt - 1'b1;
`ifdef WSEQ_SETTLE_EN
    end else if (state == SETTLE) begin
      nxt = DWELL;
      n_valid = 1'b1;
      n_cnt = (dw_tab[o_idx] == '0) ? DWELL_W'(1) : dw_tab[o_idx];
`endif
    end else if (({1'b0, o_idx} + 1'b1) < len) begin
      enter = 1'b1;
      eidx = o_idx + 1'b1;
    end else if (i_loop) begin
      enter = 1'b1;
    end else begin
      nxt = IDLE;
      n_valid = 1'b0;
      n_busy = 1'b0;
      n_done = 1'b1;
    end
    dw = (dw_tab[eidx] == '0) ? DWELL_W'(1) : dw_tab[eidx];
    if (enter) begin
      n_phi = phi_tab[eidx];
      n_idx = eidx;
      n_step = 1'b1;
      n_busy = 1'b1;
`ifdef WSEQ_SETTLE_EN
      nxt = SETTLE;
      n_valid = 1'b0;
      n_cnt = DWELL_W'(SETTLE_CYC);
`else
      nxt = DWELL;
      n_valid = 1'b1;
      n_cnt = dw;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      o_phi <= '0;
      o_idx <= '0;
      o_valid <= 1'b0;
      o_step <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        phi_tab[i] <= '0;
        dw_tab[i] <= '0;
      end
    end else begin
      state <= nxt;
      cnt <= n_cnt;
      len <= n_len;
      o_phi <= n_phi;
      o_idx <= n_idx;
      o_valid <= n_valid;
      o_step <= n_step;
      o_busy <= n_busy;
      o_done <= n_done;
      if (i_wr_en && state == IDLE) begin
        phi_tab[i_wr_addr] <= i_wr_phi;
        dw_tab[i_wr_addr] <= i_wr_dwell;
      end
    end
  end
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl: directed bench for wave_seq_ctrl; obs packs {phi, idx, step, valid, busy, done}.
module tb_wave_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [2:0]  i_wr_addr = '0;
  logic [15:0] i_wr_phi = '0;
  logic [23:0] i_wr_dwell = '0;
  logic [3:0]  i_len = '0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_loop = 1'b0;
  logic [15:0] o_phi;
  logic        o_valid, o_step, o_busy, o_done;
  logic [2:0]  o_idx;
  logic [22:0] obs;
  int          vecs = 0;
  int          errs = 0;

  wave_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_phi(i_wr_phi), .i_wr_dwell(i_wr_dwell), .i_len(i_len),
    .i_start(i_start), .i_stop(i_stop), .i_loop(i_loop), .o_phi(o_phi),
    .o_valid(o_valid), .o_step(o_step), .o_idx(o_idx), .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;
  assign obs = {o_phi, o_idx, o_step, o_valid, o_busy, o_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] p, input logic [23:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_phi = p; i_wr_dwell = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic go(input logic [3:0] len);
    i_len = len; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Expected outputs for cycle p (0..8) of the three-step table {2145,5},{4290,3},{8579,0}.
  function automatic logic [22:0] exp3(input int p);
    logic [15:0] phi;
    logic [2:0] idx;
    phi = (p < 5) ? 16'd2145 : (p < 8) ? 16'd4290 : 16'd8579;
    idx = (p < 5) ? 3'd0 : (p < 8) ? 3'd1 : 3'd2;
    return {phi, idx, (p == 0 || p == 5 || p == 8), 1'b1, 1'b1, 1'b0};
  endfunction

  localparam logic [22:0] DONE3 = {16'd8579, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_reset();
    #1;
    vecs++;
    if (obs !== 23'd0) begin errs++; $display("FAIL reset: got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_step();
    wr(3'd0, 16'd2145, 24'd5);
    wr(3'd1, 16'd4290, 24'd3);
    wr(3'd2, 16'd8579, 24'd0);
    go(4'd3);
    for (int c = 0; c < 9; c++) begin
      vecs++;
      if (obs !== exp3(c)) begin errs++; $display("FAIL three_step c%0d: got %h want %h", c, obs, exp3(c)); end
      tick();
    end
    vecs++;
    if (obs !== DONE3) begin errs++; $display("FAIL three_step done: got %h want %h", obs, DONE3); end
    tick();
    vecs++;
    if (o_done !== 1'b0) begin errs++; $display("FAIL three_step done_pulse: got %b want 0", o_done); end
  endtask

  task automatic test_loop();
    i_loop = 1'b1;
    go(4'd3);
    for (int c = 0; c < 18; c++) begin
      vecs++;
      if (obs !== exp3(c % 9)) begin errs++; $display("FAIL loop c%0d: got %h want %h", c, obs, exp3(c % 9)); end
      if (c == 14) i_loop = 1'b0;
      tick();
    end
    vecs++;
    if (obs !== DONE3) begin errs++; $display("FAIL loop done: got %h want %h", obs, DONE3); end
    tick();
  endtask

  task automatic test_stop();
    logic [22:0] e;
    e = {16'd4290, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    go(4'd3);
    for (int c = 0; c < 7; c++) begin
      vecs++;
      if (obs !== exp3(c)) begin errs++; $display("FAIL stop pre c%0d: got %h want %h", c, obs, exp3(c)); end
      if (c == 6) begin i_stop = 1'b1; i_start = 1'b1; end
      tick();
    end
    i_stop = 1'b0; i_start = 1'b0;
    vecs++;
    if (obs !== e) begin errs++; $display("FAIL stop: got %h want %h", obs, e); end
    tick();
    vecs++;
    if (obs !== e) begin errs++; $display("FAIL stop_hold: got %h want %h", obs, e); end
  endtask

  task automatic test_busy_write();
    bit seen;
    go(4'd3);
    tick();
    wr(3'd0, 16'd999, 24'd2);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (o_done) seen = 1; else tick();
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL busy_write timeout: got no done want done"); end
    tick();
    go(4'd1);
    vecs++;
    if (o_phi !== 16'd2145) begin errs++; $display("FAIL busy_write phi: got %0d want 2145", o_phi); end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_zero_len();
    go(4'd0);
    vecs++;
    if ({o_busy, o_step, o_valid} !== 3'b000) begin
      errs++; $display("FAIL zero_len: got busy/step/valid %b want 000", {o_busy, o_step, o_valid});
    end
  endtask

  task automatic test_overlong();
    int steps;
    bit seen;
    for (int i = 3; i < 8; i++) wr(3'(i), 16'(100 + i), 24'd1);
    go(4'd12);
    steps = 0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (o_done) seen = 1;
      else begin
        if (o_step) steps++;
        tick();
      end
    end
    vecs++;
    if (!seen || steps != 8) begin errs++; $display("FAIL overlong steps: got %0d (done=%0d) want 8", steps, seen); end
    vecs++;
    if ({o_phi, o_idx} !== {16'd107, 3'd7}) begin
      errs++; $display("FAIL overlong last: got phi %0d idx %0d want 107 7", o_phi, o_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    go(4'd3);
    for (int c = 0; c < 6; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (obs !== 23'd0) begin errs++; $display("FAIL reset_mid: got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    go(4'd1);
    vecs++;
    if (obs !== {16'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errs++; $display("FAIL reset_mid cleared: got %h want %h", obs, {16'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    end
    tick();
    vecs++;
    if (obs !== 23'd1) begin errs++; $display("FAIL reset_mid done: got %h want 000001", obs); end
  endtask

  task automatic test_settle();
    logic [22:0] e;
    wr(3'd0, 16'd2145, 24'd5);
    go(4'd1);
    for (int c = 0; c < 25; c++) begin
      e = {16'd2145, 3'd0, (c == 0), (c >= 20), 1'b1, 1'b0};
      vecs++;
      if (obs !== e) begin errs++; $display("FAIL settle c%0d: got %h want %h", c, obs, e); end
      tick();
    end
    vecs++;
    if (obs !== {16'd2145, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errs++; $display("FAIL settle done: got %h want %h", obs, {16'd2145, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
  endtask

  initial begin
    test_reset();
`ifdef WSEQ_SETTLE_EN
    test_settle();
`else
    test_three_step();
    test_loop();
    test_stop();
    test_busy_write();
    test_zero_len();
    test_overlong();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
